// File: rtl/irq_pkg.sv
// Shared types and constants for the accelerator interrupt arbiter.
package irq_pkg;

  localparam int          NUM_SRC      = 4;
  localparam logic [31:0] VEC_BASE_DEF = 32'h0000_01F0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // Byte offset of a vector slot inside the 16-byte aligned table.
  function automatic logic [3:0] vec_offset(input logic [1:0] id);
    return {id, 2'b00};
  endfunction

endpackage

// File: rtl/irq_arbiter_prio_pick.sv
// Combinational picker: fixed lowest-index priority, or rotating priority from rr_ptr.
import irq_pkg::*;

module irq_arbiter_prio_pick (
  input  logic [3:0] req,
  input  logic [1:0] rr_ptr,
  input  logic       rr_en,
  output logic [1:0] grant,
  output logic       valid
);

  logic [1:0] start_s;
  logic [1:0] idx_s;
  logic [1:0] grant_s;

  // Scan from the farthest candidate back to the start so the nearest request wins.
  always_comb begin
    grant_s = 2'd0;
    idx_s   = 2'd0;
    start_s = rr_en ? rr_ptr : 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx_s   = start_s + 2'(k);
      grant_s = req[idx_s] ? idx_s : grant_s;
    end
  end

  assign grant = grant_s;
  assign valid = |req;

endmodule

// File: rtl/irq_arbiter.sv
// Latches accelerator done events, arbitrates, and runs the request/ack/eret handshake
// so that at most one ISR is in flight.
import irq_pkg::*;

module irq_arbiter #(
  parameter int          NUM_SRC     = irq_pkg::NUM_SRC,
  parameter logic [31:0] VEC_BASE    = irq_pkg::VEC_BASE_DEF,
  parameter int          ROUND_ROBIN = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] done_i,
  input  logic               int_en,
  input  logic               int_ack,
  input  logic               eret,
  output logic               irq,
  output logic [1:0]         vec_id,
  output logic [31:0]        vec_addr,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] lost,
  output logic               busy
);

  localparam logic RR_EN = (ROUND_ROBIN != 0);

  irq_state_e         state_r, next_state_s;
  logic [NUM_SRC-1:0] done_q_r;
  logic [NUM_SRC-1:0] pending_r;
  logic [NUM_SRC-1:0] lost_r;
  logic [1:0]         vec_id_r;
  logic [31:0]        vec_addr_r;
  logic [1:0]         rr_ptr_r;
  logic               irq_r;
  logic               busy_r;

  logic [NUM_SRC-1:0] event_s;
  logic [NUM_SRC-1:0] ack_clr_s;
  logic [NUM_SRC-1:0] pending_next_s;
  logic [NUM_SRC-1:0] lost_set_s;
  logic [1:0]         pick_id_s;
  logic               pick_valid_s;
  logic               load_s;
  logic               ack_s;

  irq_arbiter_prio_pick u_pick (
    .req    (pending_r),
    .rr_ptr (rr_ptr_r),
    .rr_en  (RR_EN),
    .grant  (pick_id_s),
    .valid  (pick_valid_s)
  );

  // A new event beats an ack-clear of the same source, and then is not counted as lost.
  assign event_s        = done_i & ~done_q_r;
  assign ack_clr_s      = ack_s ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << vec_id_r) : {NUM_SRC{1'b0}};
  assign pending_next_s = (pending_r & ~ack_clr_s) | event_s;
  assign lost_set_s     = event_s & pending_r & ~ack_clr_s;

  // Handshake next-state logic; the grant is loaded only when leaving IDLE.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    ack_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (int_en && pick_valid_s) begin
          next_state_s = REQ;
          load_s       = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        if (int_ack) begin
          next_state_s = SERVICE;
          ack_s        = 1'b1;
        end else if (!int_en) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = REQ;
        end
      end
      SERVICE: begin
        if (eret) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = SERVICE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, event latches and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      done_q_r   <= {NUM_SRC{1'b0}};
      pending_r  <= {NUM_SRC{1'b0}};
      lost_r     <= {NUM_SRC{1'b0}};
      vec_id_r   <= 2'd0;
      vec_addr_r <= VEC_BASE;
      rr_ptr_r   <= 2'd0;
      irq_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      done_q_r  <= done_i;
      pending_r <= pending_next_s;
      lost_r    <= lost_r | lost_set_s;
      irq_r     <= (next_state_s == REQ);
      busy_r    <= (next_state_s == SERVICE);
      if (load_s) begin
        vec_id_r   <= pick_id_s;
        vec_addr_r <= {VEC_BASE[31:4], VEC_BASE[3:0] + vec_offset(pick_id_s)};
      end
      if (ack_s && RR_EN) begin
        rr_ptr_r <= vec_id_r + 2'd1;
      end
    end
  end

  assign irq      = irq_r;
  assign busy     = busy_r;
  assign vec_id   = vec_id_r;
  assign vec_addr = vec_addr_r;
  assign pending  = pending_r;
  assign lost     = lost_r;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench: a fixed-priority and a round-robin instance share the same stimulus.
module tb_irq_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  done_i;
  logic        int_en, int_ack, eret;

  logic        irq, busy, irq_rr, busy_rr;
  logic [1:0]  vec_id, vec_id_rr;
  logic [31:0] vec_addr, vec_addr_rr;
  logic [3:0]  pending, lost, pending_rr, lost_rr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  irq_arbiter dut (
    .clk(clk), .reset(reset), .done_i(done_i), .int_en(int_en), .int_ack(int_ack),
    .eret(eret), .irq(irq), .vec_id(vec_id), .vec_addr(vec_addr), .pending(pending),
    .lost(lost), .busy(busy)
  );

  irq_arbiter #(.ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .reset(reset), .done_i(done_i), .int_en(int_en), .int_ack(int_ack),
    .eret(eret), .irq(irq_rr), .vec_id(vec_id_rr), .vec_addr(vec_addr_rr),
    .pending(pending_rr), .lost(lost_rr), .busy(busy_rr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    done_i  = 4'b0000;
    int_ack = 1'b0;
    eret    = 1'b0;
    reset   = 1'b1;
    tick();
    reset   = 1'b0;
  endtask

  task automatic serve_one();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    eret    = 1'b1; tick(); eret    = 1'b0;
  endtask

  logic [1:0] exp_rr;

  initial begin
    reset = 1'b1; done_i = 4'b0000; int_en = 1'b0; int_ack = 1'b0; eret = 1'b0;
    #3;
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pending", {28'd0, pending}, 32'd0);
    check("rst_lost", {28'd0, lost}, 32'd0);
    check("rst_vec_id", {30'd0, vec_id}, 32'd0);
    check("rst_vec_addr", vec_addr, 32'h0000_01F0);
    tick(); tick();
    reset = 1'b0;

    // Basic grant and two-cycle latency
    int_en = 1'b1; done_i = 4'b0010; tick();
    check("basic_pend", {28'd0, pending}, 32'h2);
    check("basic_irq_early", {31'd0, irq}, 32'd0);
    tick();
    check("basic_irq", {31'd0, irq}, 32'd1);
    check("basic_id", {30'd0, vec_id}, 32'd1);
    check("basic_addr", vec_addr, 32'h0000_01F4);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check("basic_pend_clr", {28'd0, pending}, 32'd0);
    check("basic_busy", {31'd0, busy}, 32'd1);
    check("basic_irq_srv", {31'd0, irq}, 32'd0);
    tick(); eret = 1'b1; tick(); eret = 1'b0;
    check("basic_idle", {31'd0, busy}, 32'd0);
    repeat (4) tick();
    check("basic_no_reirq", {31'd0, irq}, 32'd0);
    done_i = 4'b0000; tick();

    // Fixed priority; the rr instance has its pointer at 2 after granting 1
    done_i = 4'b1001; tick(); tick();
    check("fix_irq1", {31'd0, irq}, 32'd1);
    check("fix_addr1", vec_addr, 32'h0000_01F0);
    check("rr_addr1", vec_addr_rr, 32'h0000_01FC);
    serve_one();
    check("fix_irq_eret", {31'd0, irq}, 32'd0);
    tick();
    check("fix_irq2", {31'd0, irq}, 32'd1);
    check("fix_addr2", vec_addr, 32'h0000_01FC);
    check("rr_addr2", vec_addr_rr, 32'h0000_01F0);
    serve_one();
    done_i = 4'b0000; tick();
    check("fix_pend_empty", {28'd0, pending}, 32'd0);

    // Round robin: sources 0 and 2 re-pend during every service
    do_reset();
    done_i = 4'b0101; tick(); tick();
    for (int i = 0; i < 4; i++) begin
      exp_rr = (i % 2 == 0) ? 2'd0 : 2'd2;
      check($sformatf("rr_irq%0d", i), {31'd0, irq_rr}, 32'd1);
      check($sformatf("rr_id%0d", i), {30'd0, vec_id_rr}, {30'd0, exp_rr});
      check($sformatf("fixrr_id%0d", i), {30'd0, vec_id}, 32'd0);
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      done_i = 4'b0000; tick();
      done_i = 4'b0101; tick();
      eret = 1'b1; tick(); eret = 1'b0;
      tick();
    end

    // Withdraw and frozen grant
    do_reset();
    int_en = 1'b1; done_i = 4'b0100; tick(); tick();
    check("frz_id0", {30'd0, vec_id}, 32'd2);
    done_i = 4'b0101; tick();
    check("frz_id1", {30'd0, vec_id}, 32'd2);
    check("frz_irq", {31'd0, irq}, 32'd1);
    check("frz_pend", {28'd0, pending}, 32'h5);
    int_en = 1'b0; tick();
    check("wd_irq", {31'd0, irq}, 32'd0);
    check("wd_pend", {28'd0, pending}, 32'h5);
    tick();
    check("wd_irq_hold", {31'd0, irq}, 32'd0);
    int_en = 1'b1; tick();
    check("wd_rereq", {31'd0, irq}, 32'd1);
    check("wd_rereq_id", {30'd0, vec_id}, 32'd0);

    // Lost events and set/clear collision
    do_reset();
    int_en = 1'b0;
    done_i = 4'b0010; tick(); done_i = 4'b0000; tick(); done_i = 4'b0010; tick();
    done_i = 4'b0000; tick();
    check("lost1", {28'd0, lost}, 32'h2);
    check("lost_pend", {28'd0, pending}, 32'h2);
    int_en = 1'b1; tick();
    check("lost_id", {30'd0, vec_id}, 32'd1);
    serve_one();
    check("lost_pend_clr", {28'd0, pending}, 32'd0);
    done_i = 4'b1000; tick(); tick();
    check("col_id", {30'd0, vec_id}, 32'd3);
    done_i = 4'b0000; tick();
    done_i = 4'b1000; int_ack = 1'b1; tick(); int_ack = 1'b0;
    check("col_pend", {28'd0, pending}, 32'h8);
    check("col_lost", {28'd0, lost}, 32'h2);
    check("col_busy", {31'd0, busy}, 32'd1);
    eret = 1'b1; tick(); eret = 1'b0; tick();
    check("col_reserve_irq", {31'd0, irq}, 32'd1);
    check("col_reserve_id", {30'd0, vec_id}, 32'd3);

    // Asynchronous reset while in SERVICE with pending = 1010
    do_reset();
    int_en = 1'b1; done_i = 4'b1010; tick(); tick();
    done_i = 4'b1000; int_ack = 1'b1; tick(); int_ack = 1'b0;
    done_i = 4'b1010; tick();
    check("ar_pend_pre", {28'd0, pending}, 32'hA);
    check("ar_busy_pre", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_irq", {31'd0, irq}, 32'd0);
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_pend", {28'd0, pending}, 32'd0);
    check("ar_lost", {28'd0, lost}, 32'd0);
    check("ar_id", {30'd0, vec_id}, 32'd0);
    check("ar_addr", vec_addr, 32'h0000_01F0);
    tick();
    reset = 1'b0; done_i = 4'b0000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
